// File: rtl/phase_cmd_pkg.sv
// phase_cmd_pkg
//
// Shared definitions for the host phase command path: command opcodes,
// error codes, the command decoder state encoding and the bit layout of
// the 32-bit phase word. The per-channel phase parsers import the same
// field constants, so the word layout is defined in exactly one place.
//
// Phase word layout:
//   [31:17] zero
//   [16]    enable
//   [15:8]  channel
//   [7:0]   phase
`timescale 1ns/1ps

package phase_cmd_pkg;

    // Command opcodes (first byte of every command).
    localparam logic [7:0] OP_SET   = 8'h01;
    localparam logic [7:0] OP_BURST = 8'h02;
    localparam logic [7:0] OP_CALIB = 8'h03;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_OP  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CHANNEL = 2'd3;

    // Phase word field positions.
    localparam int WORD_W     = 32;
    localparam int ENABLE_BIT = 16;
    localparam int CH_MSB     = 15;
    localparam int CH_LSB     = 8;
    localparam int PHASE_MSB  = 7;
    localparam int PHASE_LSB  = 0;

    // Command decoder states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SET_CH     = 3'd1,
        SET_PH     = 3'd2,
        SET_EN     = 3'd3,
        BURST_CH   = 3'd4,
        BURST_CNT  = 3'd5,
        BURST_DATA = 3'd6
    } state_t;

    // Assemble a phase word from its fields; unused upper bits are zero.
    function automatic logic [WORD_W-1:0] make_word(
        input logic       en,
        input logic [7:0] ch,
        input logic [7:0] phase
    );
        logic [WORD_W-1:0] w;
        w                      = '0;
        w[ENABLE_BIT]          = en;
        w[CH_MSB:CH_LSB]       = ch;
        w[PHASE_MSB:PHASE_LSB] = phase;
        return w;
    endfunction

    // True when the channel number addresses an existing parser.
    function automatic logic channel_valid(
        input logic [7:0] ch,
        input int         num_channels
    );
        return (int'({24'd0, ch}) < num_channels);
    endfunction

endpackage

// File: rtl/phase_word_writer.sv
// phase_word_writer
//
// Host-side command front end. Decodes a byte stream from the host link
// into 32-bit phase words for the channel parsers and drives the shared
// phase_data bus with one-cycle strobes.
//
// Commands (first byte is the opcode):
//   0x01 SET   ch, phase, en          -> one word {en[0], ch, phase}
//   0x02 BURST start_ch, count, count phase bytes
//                                     -> one word per byte, channel
//                                        start_ch+i (mod 256), enable=1
//   0x03 CALIB                        -> one phase_calib_en pulse
//   other                             -> err code 1, byte dropped
//
// Parameters:
//   NUM_CHANNELS    number of valid target channels (1..256)
//   TIMEOUT_CYCLES  idle cycles allowed between bytes of one command (>=1)
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   in_valid        host byte valid
//   in_data         host byte
//   in_ready        byte accepted when in_valid && in_ready (never stalls)
//   phase_data      last emitted phase word, held between strobes
//   phase_parse_en  one-cycle strobe, phase_data valid this cycle
//   phase_calib_en  one-cycle strobe, parsers latch phase as calibration
//   busy            high whenever a command is in progress
//   err             one-cycle error pulse
//   err_code        code of the most recent error, held until the next one
//
// Handshake: a byte transfers on every rising clk edge where in_valid and
// in_ready are both high. in_ready is low only during reset, so the host
// may present one byte per cycle indefinitely. All outputs except busy and
// in_ready are registered and appear the cycle after the byte that caused
// them.
`timescale 1ns/1ps

module phase_word_writer
    import phase_cmd_pkg::*;
#(
    parameter int NUM_CHANNELS   = 64,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [WORD_W-1:0] phase_data,
    output logic              phase_parse_en,
    output logic              phase_calib_en,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    // Idle counter sized to hold TIMEOUT_CYCLES. The command expires in the
    // cycle where the count would reach TIMEOUT_CYCLES with no byte
    // arriving, so the last legal value before expiry is TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state,      state_next;
    logic [7:0]       ch_q,       ch_next;        // SET channel
    logic [7:0]       ph_q,       ph_next;        // SET phase
    logic [7:0]       burst_ch_q, burst_ch_next;  // next BURST channel
    logic [7:0]       remain_q,   remain_next;    // BURST bytes left
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_next;

    logic [WORD_W-1:0] data_next;
    logic              parse_next;
    logic              calib_next;
    logic              err_next;
    logic [1:0]        code_next;

    // Word request raised by the decoder; range check happens once below.
    logic              word_req;
    logic              word_en;
    logic [7:0]        word_ch;
    logic [7:0]        word_phase;

    logic              accept;

    assign in_ready = !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        ch_next       = ch_q;
        ph_next       = ph_q;
        burst_ch_next = burst_ch_q;
        remain_next   = remain_q;
        idle_cnt_next = idle_cnt_q;
        data_next     = phase_data;
        parse_next    = 1'b0;
        calib_next    = 1'b0;
        err_next      = 1'b0;
        code_next     = err_code;
        word_req      = 1'b0;
        word_en       = 1'b0;
        word_ch       = 8'd0;
        word_phase    = 8'd0;

        // Inter-byte timeout. A byte accepted in the expiry cycle takes
        // priority, so the timeout branch only fires without an accept and
        // never competes with the decoder below.
        if (state == IDLE) begin
            idle_cnt_next = '0;
        end else if (accept) begin
            idle_cnt_next = '0;
        end else if (idle_cnt_q == TIMEOUT_LAST) begin
            idle_cnt_next = '0;
            state_next    = IDLE;
            err_next      = 1'b1;
            code_next     = ERR_TIMEOUT;
        end else begin
            idle_cnt_next = idle_cnt_q + CNT_W'(1);
        end

        if (accept) begin
            case (state)
                IDLE: begin
                    case (in_data)
                        OP_SET:   state_next = SET_CH;
                        OP_BURST: state_next = BURST_CH;
                        OP_CALIB: calib_next = 1'b1;
                        default: begin
                            err_next  = 1'b1;
                            code_next = ERR_BAD_OP;
                        end
                    endcase
                end

                SET_CH: begin
                    ch_next    = in_data;
                    state_next = SET_PH;
                end

                SET_PH: begin
                    ph_next    = in_data;
                    state_next = SET_EN;
                end

                SET_EN: begin
                    // Only bit 0 of the enable byte is meaningful.
                    word_req   = 1'b1;
                    word_en    = in_data[0];
                    word_ch    = ch_q;
                    word_phase = ph_q;
                    state_next = IDLE;
                end

                BURST_CH: begin
                    burst_ch_next = in_data;
                    state_next    = BURST_CNT;
                end

                BURST_CNT: begin
                    remain_next = in_data;
                    state_next  = (in_data == 8'd0) ? IDLE : BURST_DATA;
                end

                BURST_DATA: begin
                    word_req      = 1'b1;
                    word_en       = 1'b1;
                    word_ch       = burst_ch_q;
                    word_phase    = in_data;
                    // Channel wraps modulo 256 through the 8-bit add.
                    burst_ch_next = burst_ch_q + 8'd1;
                    remain_next   = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // An out-of-range channel suppresses the word but not the command:
        // a burst simply moves on to the next channel.
        if (word_req) begin
            if (channel_valid(word_ch, NUM_CHANNELS)) begin
                data_next  = make_word(word_en, word_ch, word_phase);
                parse_next = 1'b1;
            end else begin
                err_next  = 1'b1;
                code_next = ERR_CHANNEL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ch_q           <= 8'd0;
            ph_q           <= 8'd0;
            burst_ch_q     <= 8'd0;
            remain_q       <= 8'd0;
            idle_cnt_q     <= '0;
            phase_data     <= '0;
            phase_parse_en <= 1'b0;
            phase_calib_en <= 1'b0;
            err            <= 1'b0;
            err_code       <= ERR_NONE;
        end else begin
            state          <= state_next;
            ch_q           <= ch_next;
            ph_q           <= ph_next;
            burst_ch_q     <= burst_ch_next;
            remain_q       <= remain_next;
            idle_cnt_q     <= idle_cnt_next;
            phase_data     <= data_next;
            phase_parse_en <= parse_next;
            phase_calib_en <= calib_next;
            err            <= err_next;
            err_code       <= code_next;
        end
    end

endmodule

// File: tb/tb_phase_word_writer.sv
// tb_phase_word_writer
//
// Directed bench for phase_word_writer. Two instances share one host byte
// stream: dut_a has 64 channels (range errors), dut_b has 256 channels
// (burst channel wrap). Both use an 8-cycle timeout. Inputs change 1 ns
// after the rising edge and outputs are inspected at the same point, so the
// registered outputs seen right after send() belong to that byte.
`timescale 1ns/1ps

module tb_phase_word_writer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        ready_a, ready_b;
    logic [31:0] data_a,  data_b;
    logic        parse_a, parse_b;
    logic        calib_a, calib_b;
    logic        busy_a,  busy_b;
    logic        err_a,   err_b;
    logic [1:0]  code_a,  code_b;

    int vectors;
    int fails;

    phase_word_writer #(.NUM_CHANNELS(64), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_a), .phase_data(data_a), .phase_parse_en(parse_a),
        .phase_calib_en(calib_a), .busy(busy_a), .err(err_a), .err_code(code_a)
    );

    phase_word_writer #(.NUM_CHANNELS(256), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_b), .phase_data(data_b), .phase_parse_en(parse_b),
        .phase_calib_en(calib_b), .busy(busy_b), .err(err_b), .err_code(code_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "time limit");
    end

    // Driver: present one byte for one cycle, then return 1 ns after the
    // accepting edge.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (data_a !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 00000000", data_a); end
        vectors++; if (parse_a !== 1'b0) begin fails++; $display("FAIL reset_parse: got %b want 0", parse_a); end
        vectors++; if (calib_a !== 1'b0) begin fails++; $display("FAIL reset_calib: got %b want 0", calib_a); end
        vectors++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        vectors++; if (err_a !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_a); end
        vectors++; if (code_a !== 2'd0) begin fails++; $display("FAIL reset_code: got %0d want 0", code_a); end
        vectors++; if (ready_a !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b want 0", ready_a); end
        rst = 1'b0;
        #1;
        vectors++; if (ready_a !== 1'b1) begin fails++; $display("FAIL reset_ready_high: got %b want 1", ready_a); end
        vectors++; if (ready_b !== 1'b1) begin fails++; $display("FAIL reset_ready_high_b: got %b want 1", ready_b); end
    endtask

    task automatic test_set();
        send(8'h01);
        send(8'h05);
        send(8'h80);
        vectors++; if (parse_a !== 1'b0) begin fails++; $display("FAIL set_early_strobe: got %b want 0", parse_a); end
        vectors++; if (busy_a !== 1'b1) begin fails++; $display("FAIL set_busy: got %b want 1", busy_a); end
        send(8'h01);
        vectors++; if (parse_a !== 1'b1) begin fails++; $display("FAIL set_strobe: got %b want 1", parse_a); end
        vectors++; if (data_a !== 32'h0001_0580) begin fails++; $display("FAIL set_word: got %h want 00010580", data_a); end
        vectors++; if (busy_a !== 1'b0) begin fails++; $display("FAIL set_busy_done: got %b want 0", busy_a); end
        vectors++; if (err_a !== 1'b0) begin fails++; $display("FAIL set_err: got %b want 0", err_a); end
        idle_cycle();
        vectors++; if (parse_a !== 1'b0) begin fails++; $display("FAIL set_strobe_width: got %b want 0", parse_a); end
        vectors++; if (data_a !== 32'h0001_0580) begin fails++; $display("FAIL set_word_hold: got %h want 00010580", data_a); end
        // Enable byte 0xFE: only bit 0 counts, so the word is disabled.
        send(8'h01); send(8'h03); send(8'h44); send(8'hFE);
        vectors++; if (parse_a !== 1'b1) begin fails++; $display("FAIL set_dis_strobe: got %b want 1", parse_a); end
        vectors++; if (data_a !== 32'h0000_0344) begin fails++; $display("FAIL set_dis_word: got %h want 00000344", data_a); end
    endtask

    task automatic test_back_to_back();
        // Burst from channel 0xFE across the 8-bit wrap.
        send(8'h02); send(8'hFE); send(8'h03);
        send(8'h10);
        vectors++; if (parse_b !== 1'b1) begin fails++; $display("FAIL burst0_strobe: got %b want 1", parse_b); end
        vectors++; if (data_b !== 32'h0001_FE10) begin fails++; $display("FAIL burst0_word: got %h want 0001FE10", data_b); end
        vectors++; if (parse_a !== 1'b0) begin fails++; $display("FAIL burst0_range_strobe: got %b want 0", parse_a); end
        vectors++; if (err_a !== 1'b1 || code_a !== 2'd3) begin fails++; $display("FAIL burst0_range_err: got err=%b code=%0d want err=1 code=3", err_a, code_a); end
        send(8'h20);
        vectors++; if (parse_b !== 1'b1) begin fails++; $display("FAIL burst1_strobe: got %b want 1", parse_b); end
        vectors++; if (data_b !== 32'h0001_FF20) begin fails++; $display("FAIL burst1_word: got %h want 0001FF20", data_b); end
        send(8'h30);
        vectors++; if (parse_b !== 1'b1) begin fails++; $display("FAIL burst2_strobe: got %b want 1", parse_b); end
        vectors++; if (data_b !== 32'h0001_0030) begin fails++; $display("FAIL burst2_wrap_word: got %h want 00010030", data_b); end
        vectors++; if (busy_b !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL burst_busy_done: got a=%b b=%b want 0", busy_a, busy_b); end
        vectors++; if (err_b !== 1'b0) begin fails++; $display("FAIL burst_err_b: got %b want 0", err_b); end
        idle_cycle();
        vectors++; if (parse_b !== 1'b0) begin fails++; $display("FAIL burst_end_strobe: got %b want 0", parse_b); end
        // Zero-count burst returns to IDLE with nothing emitted.
        send(8'h02); send(8'h05); send(8'h00);
        vectors++; if (busy_a !== 1'b0) begin fails++; $display("FAIL burst_zero_busy: got %b want 0", busy_a); end
        vectors++; if (parse_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL burst_zero_out: got parse=%b err=%b want 0 0", parse_a, err_a); end
        // SET followed immediately by CALIB: strobes in order, no overlap.
        send(8'h01); send(8'h09); send(8'h0F); send(8'h01);
        vectors++; if (parse_a !== 1'b1 || calib_a !== 1'b0) begin fails++; $display("FAIL b2b_set: got parse=%b calib=%b want 1 0", parse_a, calib_a); end
        vectors++; if (data_a !== 32'h0001_090F) begin fails++; $display("FAIL b2b_word: got %h want 0001090F", data_a); end
        send(8'h03);
        vectors++; if (parse_a !== 1'b0 || calib_a !== 1'b1) begin fails++; $display("FAIL b2b_calib: got parse=%b calib=%b want 0 1", parse_a, calib_a); end
    endtask

    task automatic test_bad_channel();
        send(8'h01); send(8'h50); send(8'h11); send(8'h01);
        vectors++; if (parse_a !== 1'b0) begin fails++; $display("FAIL range_strobe: got %b want 0", parse_a); end
        vectors++; if (err_a !== 1'b1) begin fails++; $display("FAIL range_err: got %b want 1", err_a); end
        vectors++; if (code_a !== 2'd3) begin fails++; $display("FAIL range_code: got %0d want 3", code_a); end
        vectors++; if (parse_b !== 1'b1 || data_b !== 32'h0001_5011) begin fails++; $display("FAIL range_b_word: got parse=%b data=%h want 1 00015011", parse_b, data_b); end
        send(8'h03);
        vectors++; if (calib_a !== 1'b1) begin fails++; $display("FAIL calib_strobe: got %b want 1", calib_a); end
        vectors++; if (err_a !== 1'b0 || code_a !== 2'd3) begin fails++; $display("FAIL calib_err_hold: got err=%b code=%0d want 0 3", err_a, code_a); end
        vectors++; if (busy_a !== 1'b0) begin fails++; $display("FAIL calib_busy: got %b want 0", busy_a); end
        idle_cycle();
        vectors++; if (calib_a !== 1'b0) begin fails++; $display("FAIL calib_width: got %b want 0", calib_a); end
    endtask

    task automatic test_bad_opcode();
        send(8'h7F);
        vectors++; if (err_a !== 1'b1 || code_a !== 2'd1) begin fails++; $display("FAIL badop_err: got err=%b code=%0d want 1 1", err_a, code_a); end
        vectors++; if (busy_a !== 1'b0) begin fails++; $display("FAIL badop_busy: got %b want 0", busy_a); end
        idle_cycle();
        vectors++; if (err_a !== 1'b0 || code_a !== 2'd1) begin fails++; $display("FAIL badop_pulse: got err=%b code=%0d want 0 1", err_a, code_a); end
        send(8'h01); send(8'h07); send(8'h22); send(8'h01);
        vectors++; if (parse_a !== 1'b1 || data_a !== 32'h0001_0722) begin fails++; $display("FAIL badop_recover: got parse=%b data=%h want 1 00010722", parse_a, data_a); end
    endtask

    task automatic test_timeout();
        send(8'h01); send(8'h05);
        repeat (7) idle_cycle();
        vectors++; if (err_a !== 1'b0 || busy_a !== 1'b1) begin fails++; $display("FAIL timeout_early: got err=%b busy=%b want 0 1", err_a, busy_a); end
        idle_cycle();
        vectors++; if (err_a !== 1'b1 || code_a !== 2'd2) begin fails++; $display("FAIL timeout_err: got err=%b code=%0d want 1 2", err_a, code_a); end
        vectors++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL timeout_busy: got a=%b b=%b want 0", busy_a, busy_b); end
        vectors++; if (parse_a !== 1'b0) begin fails++; $display("FAIL timeout_strobe: got %b want 0", parse_a); end
        idle_cycle();
        vectors++; if (err_a !== 1'b0 || code_a !== 2'd2) begin fails++; $display("FAIL timeout_pulse: got err=%b code=%0d want 0 2", err_a, code_a); end
        // A byte in the expiry cycle keeps the command alive.
        send(8'h01); send(8'h05);
        repeat (7) idle_cycle();
        send(8'h33);
        vectors++; if (err_a !== 1'b0 || busy_a !== 1'b1) begin fails++; $display("FAIL expiry_byte: got err=%b busy=%b want 0 1", err_a, busy_a); end
        send(8'h01);
        vectors++; if (parse_a !== 1'b1 || data_a !== 32'h0001_0533) begin fails++; $display("FAIL expiry_word: got parse=%b data=%h want 1 00010533", parse_a, data_a); end
    endtask

    task automatic test_reset_mid_burst();
        send(8'h02); send(8'h00); send(8'h05);
        send(8'hAA);
        vectors++; if (data_a !== 32'h0001_00AA) begin fails++; $display("FAIL rstmid_word0: got %h want 000100AA", data_a); end
        send(8'hBB);
        vectors++; if (parse_a !== 1'b1 || data_a !== 32'h0001_01BB) begin fails++; $display("FAIL rstmid_word1: got parse=%b data=%h want 1 000101BB", parse_a, data_a); end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hCC;
        @(posedge clk);
        #1;
        vectors++; if (data_a !== 32'd0 || parse_a !== 1'b0 || calib_a !== 1'b0) begin fails++; $display("FAIL rstmid_out: got data=%h parse=%b calib=%b want 0", data_a, parse_a, calib_a); end
        vectors++; if (busy_a !== 1'b0 || err_a !== 1'b0 || code_a !== 2'd0) begin fails++; $display("FAIL rstmid_ctl: got busy=%b err=%b code=%0d want 0", busy_a, err_a, code_a); end
        vectors++; if (busy_b !== 1'b0 || data_b !== 32'd0) begin fails++; $display("FAIL rstmid_b: got busy=%b data=%h want 0", busy_b, data_b); end
        rst      = 1'b0;
        in_valid = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h01);
        vectors++; if (parse_a !== 1'b1 || data_a !== 32'h0001_0203) begin fails++; $display("FAIL rstmid_recover: got parse=%b data=%h want 1 00010203", parse_a, data_a); end
        vectors++; if (err_a !== 1'b0) begin fails++; $display("FAIL rstmid_recover_err: got %b want 0", err_a); end
    endtask

    initial begin
        vectors  = 0;
        fails    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_set();
        test_back_to_back();
        test_bad_channel();
        test_bad_opcode();
        test_timeout();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
